// File: rtl/ad9958_serial_io.sv
// ad9958_serial_io
// Quad-SDIO serializer for the AD9958 serial port. One register word per
// trigger is shifted MSB-first, one nibble per SCLK cycle, on sdio_o[3:0].
// cs_n_o stays low between frames so that instruction and data transfers form
// one AD9958 communication cycle.
//
// Optional build macro: AD9958_CS_TIMEOUT_EN
//   When defined, cs_n_o deasserts after CS_IDLE_CYCLES consecutive idle
//   cycles without a trigger, which resynchronises the AD9958 serial logic.
//   When undefined, only reset_n or master_reset_i deassert cs_n_o.
//
// Handshake: trigger_i is a single-cycle request that is accepted only in IDLE
// with a non-zero length. busy_o rises on the edge that accepts it and falls
// on the edge that ends the final SCLK high phase. A trigger seen while busy
// is dropped, not queued.
module ad9958_serial_io #(
  parameter int SCLK_DIV       = 2,
  parameter int CS_IDLE_CYCLES = 64
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        master_reset_i,
  input  logic        trigger_i,
  input  logic [4:0]  packs_to_send_i,
  input  logic [63:0] data_input_i,
  output logic        busy_o,
  output logic        sclk_o,
  output logic        cs_n_o,
  output logic [3:0]  sdio_o,
  output logic [1:0]  state_o
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_SHIFT_LO = 2'd1;
  localparam logic [1:0] ST_SHIFT_HI = 2'd2;

  localparam int DIV_W  = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam int IDLE_W = $clog2(CS_IDLE_CYCLES + 1);

  // Parameter sanity: both dividers must be at least one cycle.
  if (SCLK_DIV < 1 || CS_IDLE_CYCLES < 1) begin : g_bad_cfg
    $error("ad9958_serial_io: SCLK_DIV and CS_IDLE_CYCLES must be >= 1");
  end

  logic [1:0]       state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [4:0]       nib_q, nib_d;
  logic [63:0]      shift_q, shift_d;
  logic             busy_q, busy_d;
  logic             sclk_q, sclk_d;
  logic             cs_n_q, cs_n_d;
  logic [3:0]       sdio_q, sdio_d;
`ifdef AD9958_CS_TIMEOUT_EN
  logic [IDLE_W-1:0] idle_q, idle_d;
`endif

  logic [4:0]  n_clamped;
  logic [6:0]  align_shamt;
  logic [63:0] data_aligned;
  logic        div_last;

  // Length clamp and left-alignment so the first nibble always sits at [63:60].
  always_comb begin
    n_clamped    = (packs_to_send_i > 5'd16) ? 5'd16 : packs_to_send_i;
    align_shamt  = 7'd64 - {n_clamped, 2'b00};
    data_aligned = data_input_i << align_shamt;
    div_last     = (div_q == DIV_W'(SCLK_DIV - 1));
  end

  // Next-state logic for the serializer FSM and its datapath.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    nib_d   = nib_q;
    shift_d = shift_q;
    busy_d  = busy_q;
    sclk_d  = sclk_q;
    cs_n_d  = cs_n_q;
    sdio_d  = sdio_q;
`ifdef AD9958_CS_TIMEOUT_EN
    idle_d  = idle_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (trigger_i && (n_clamped != 5'd0)) begin
          shift_d = data_aligned;
          nib_d   = n_clamped;
          sdio_d  = data_aligned[63:60];
          cs_n_d  = 1'b0;
          busy_d  = 1'b1;
          sclk_d  = 1'b0;
          div_d   = '0;
          state_d = ST_SHIFT_LO;
`ifdef AD9958_CS_TIMEOUT_EN
          idle_d  = '0;
`endif
        end
`ifdef AD9958_CS_TIMEOUT_EN
        else if (trigger_i) begin
          idle_d = '0;
        end else if (!cs_n_q) begin
          if (idle_q == IDLE_W'(CS_IDLE_CYCLES - 1)) begin
            cs_n_d = 1'b1;
            idle_d = '0;
          end else begin
            idle_d = idle_q + 1'b1;
          end
        end
`endif
      end
      ST_SHIFT_LO: begin
        if (div_last) begin
          div_d   = '0;
          sclk_d  = 1'b1;
          state_d = ST_SHIFT_HI;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      ST_SHIFT_HI: begin
        if (div_last) begin
          div_d  = '0;
          sclk_d = 1'b0;
          nib_d  = nib_q - 5'd1;
          if (nib_q == 5'd1) begin
            // Last nibble stays on the pins; the idle counter restarts here.
            busy_d  = 1'b0;
            state_d = ST_IDLE;
`ifdef AD9958_CS_TIMEOUT_EN
            idle_d  = '0;
`endif
          end else begin
            shift_d = shift_q << 4;
            sdio_d  = shift_q[59:56];
            state_d = ST_SHIFT_LO;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset and master reset both abort any partial frame.
  always_ff @(posedge clock) begin
    if (!reset_n || master_reset_i) begin
      state_q <= ST_IDLE;
      div_q   <= '0;
      nib_q   <= '0;
      shift_q <= '0;
      busy_q  <= 1'b0;
      sclk_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      sdio_q  <= 4'h0;
`ifdef AD9958_CS_TIMEOUT_EN
      idle_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      nib_q   <= nib_d;
      shift_q <= shift_d;
      busy_q  <= busy_d;
      sclk_q  <= sclk_d;
      cs_n_q  <= cs_n_d;
      sdio_q  <= sdio_d;
`ifdef AD9958_CS_TIMEOUT_EN
      idle_q  <= idle_d;
`endif
    end
  end

  assign busy_o  = busy_q;
  assign sclk_o  = sclk_q;
  assign cs_n_o  = cs_n_q;
  assign sdio_o  = sdio_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_ad9958_serial_io.sv
// Testbench for ad9958_serial_io (SCLK_DIV = 2). Expected nibbles and busy
// lengths are queued when a frame is requested and consumed by a monitor that
// watches SCLK rises and busy falls.
module tb_ad9958_serial_io;

  localparam int SCLK_DIV = 2;

  logic        clock;
  logic        reset_n;
  logic        master_reset;
  logic        trigger;
  logic [4:0]  packs_to_send;
  logic [63:0] data_input;
  logic        busy;
  logic        sclk;
  logic        cs_n;
  logic [3:0]  sdio;
  logic [1:0]  state;

  int checks   = 0;
  int failures = 0;

  logic [3:0] exp_q[$];
  int         exp_busy_q[$];

  ad9958_serial_io #(.SCLK_DIV(SCLK_DIV), .CS_IDLE_CYCLES(64)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .master_reset_i (master_reset),
    .trigger_i      (trigger),
    .packs_to_send_i(packs_to_send),
    .data_input_i   (data_input),
    .busy_o         (busy),
    .sclk_o         (sclk),
    .cs_n_o         (cs_n),
    .sdio_o         (sdio),
    .state_o        (state)
  );

  // Clock and reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Monitor / scoreboard: pop one nibble per SCLK rise, one length per busy fall.
  logic       prev_sclk = 1'b0;
  logic [3:0] held_sdio = 4'h0;
  int         busy_cnt  = 0;
  always @(negedge clock) begin
    if (sclk === 1'b1 && prev_sclk === 1'b0) begin
      if (exp_q.size() == 0) check("extra_sclk_rise", 64'd1, 64'd0);
      else check("sdio_at_rise", {60'd0, sdio}, {60'd0, exp_q.pop_front()});
      held_sdio = sdio;
    end else if (sclk === 1'b1) begin
      check("sdio_hold_high", {60'd0, sdio}, {60'd0, held_sdio});
    end
    prev_sclk = sclk;
    if (busy === 1'b1) begin
      busy_cnt++;
    end else if (busy_cnt > 0) begin
      if (exp_busy_q.size() == 0) check("unexpected_busy", 64'(busy_cnt), 64'd0);
      else check("busy_len", 64'(busy_cnt), 64'(exp_busy_q.pop_front()));
      busy_cnt = 0;
    end
  end

  // Drivers
  task automatic push_frame(input int n, input logic [63:0] data);
    int nc;
    logic [63:0] d;
    nc = (n > 16) ? 16 : n;
    for (int i = 0; i < nc; i++) begin
      d = data >> (4 * (nc - 1 - i));
      exp_q.push_back(d[3:0]);
    end
    if (nc > 0) exp_busy_q.push_back(2 * SCLK_DIV * nc);
  endtask

  task automatic pulse_trigger(input int n, input logic [63:0] data);
    @(negedge clock);
    packs_to_send = 5'(n);
    data_input    = data;
    trigger       = 1'b1;
    @(negedge clock);
    trigger       = 1'b0;
  endtask

  task automatic send(input int n, input logic [63:0] data);
    push_frame(n, data);
    pulse_trigger(n, data);
    check("busy_rise", {63'd0, busy}, {63'd0, (n != 0)});
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy === 1'b1 && k < 200) begin
      @(negedge clock);
      k++;
    end
    if (k >= 200) check("busy_timeout", 64'd1, 64'd0);
  endtask

  initial begin
    reset_n = 1'b0; master_reset = 1'b0; trigger = 1'b0;
    packs_to_send = '0; data_input = '0;
    repeat (3) @(negedge clock);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_sclk", {63'd0, sclk}, 64'd0);
    check("rst_cs_n", {63'd0, cs_n}, 64'd1);
    check("rst_sdio", {60'd0, sdio}, 64'd0);
    check("rst_state", {62'd0, state}, 64'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);

    // Instruction byte, then CSR data byte
    send(2, 64'h00);
    wait_idle();
    check("cs_low_after_instr", {63'd0, cs_n}, 64'd0);
    send(2, 64'h46);
    wait_idle();
    check("sdio_keeps_last", {60'd0, sdio}, 64'h6);

    // FTW, then zero-length request
    send(8, 64'h12345678);
    wait_idle();
    send(0, 64'hFF);
    repeat (6) begin
      @(negedge clock);
      check("n0_no_busy", {63'd0, busy}, 64'd0);
    end

    // Trigger during a frame is ignored
    send(8, 64'hA1B2C3D4);
    repeat (2) @(negedge clock);
    trigger = 1'b1; packs_to_send = 5'd4; data_input = 64'hFFFF;
    @(negedge clock);
    trigger = 1'b0;
    wait_idle();

    // Over-long request clamps to 16 nibbles
    send(20, 64'hFEDCBA9876543210);
    wait_idle();

    // Back-to-back: trigger on the first cycle after busy falls
    send(3, 64'h9C7);
    wait_idle();
    push_frame(1, 64'h5);
    packs_to_send = 5'd1; data_input = 64'h5; trigger = 1'b1;
    @(negedge clock);
    trigger = 1'b0;
    check("b2b_busy", {63'd0, busy}, 64'd1);
    wait_idle();

    // master_reset sampled on cycle 5 of a 32-cycle frame: one rise seen
    exp_q.push_back(4'hD);
    exp_busy_q.push_back(5);
    pulse_trigger(8, 64'hDEADBEEF);
    repeat (4) @(negedge clock);
    master_reset = 1'b1; trigger = 1'b1;
    @(negedge clock);
    master_reset = 1'b0; trigger = 1'b0;
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_sclk", {63'd0, sclk}, 64'd0);
    check("abort_cs_n", {63'd0, cs_n}, 64'd1);
    check("abort_sdio", {60'd0, sdio}, 64'd0);
    check("abort_state", {62'd0, state}, 64'd0);
    repeat (3) @(negedge clock);
    send(2, 64'hA5);
    wait_idle();
    check("post_abort_cs_n", {63'd0, cs_n}, 64'd0);

`ifdef AD9958_CS_TIMEOUT_EN
    begin
      int k;
      // Trigger at idle cycle 63 keeps cs_n low
      repeat (62) @(negedge clock);
      check("cs_before_timeout", {63'd0, cs_n}, 64'd0);
      send(1, 64'h3);
      wait_idle();
      k = 0;
      while (cs_n === 1'b0 && k < 200) begin
        @(negedge clock);
        k++;
      end
      check("cs_timeout_cycles", 64'(k), 64'd64);
    end
`else
    repeat (100) @(negedge clock);
    check("cs_held_low", {63'd0, cs_n}, 64'd0);
`endif

    repeat (4) @(negedge clock);
    check("nibbles_left", 64'(exp_q.size()), 64'd0);
    check("busy_left", 64'(exp_busy_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
